// File: rtl/hazard_source_pipe_pkg.sv
// Shared definitions for the control-side pipeline that feeds the hazard unit.
package hazard_source_pipe_pkg;

  // Register address width and the register index that holds the PC.
  localparam int unsigned RA_W   = 4;
  localparam int unsigned PC_REG = 15;

  // Decoded control bits carried from stage to stage.
  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemWrite;
    logic PCSrc;
    logic Branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_source_pipe_ctrl_stage_reg.sv
// One pipeline register for control bits plus a destination address.
// Flush turns the stage into a bubble and overrides the enable.
module ctrl_stage_reg
  import hazard_source_pipe_pkg::*;
#(
  parameter int unsigned AW = RA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          flush_i,
  input  ctrl_t         ctrl_i,
  input  logic [AW-1:0] wa3_i,
  output ctrl_t         ctrl_o,
  output logic [AW-1:0] wa3_o
);

  ctrl_t         ctrl_q, ctrl_d;
  logic [AW-1:0] wa3_q, wa3_d;

  // Next state: a flush clears control bits, otherwise load when enabled.
  always_comb begin
    ctrl_d = ctrl_q;
    wa3_d  = wa3_q;
    if (flush_i) begin
      ctrl_d = CTRL_NOP;
      wa3_d  = wa3_i;
    end else if (en_i) begin
      ctrl_d = ctrl_i;
      wa3_d  = wa3_i;
    end
  end

  // Stage state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_NOP;
      wa3_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      wa3_q  <= wa3_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign wa3_o  = wa3_q;

endmodule

// File: rtl/hazard_source_pipe.sv
// Control-side D/E/M/W pipeline. Carries decoded control bits and register
// addresses, applies the Execute condition check, and produces the match and
// control signals the hazard unit consumes while obeying its stall/flush.
module hazard_source_pipe #(
  parameter int unsigned RA_W   = hazard_source_pipe_pkg::RA_W,
  parameter int unsigned PC_REG = hazard_source_pipe_pkg::PC_REG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] RA1D,
  input  logic [RA_W-1:0] RA2D,
  input  logic [RA_W-1:0] WA3D,
  input  logic            UseRA1D,
  input  logic            UseRA2D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            MemWriteD,
  input  logic            PCSrcD_raw,
  input  logic            BranchD,
  input  logic            CondExE,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  output logic            PCSrcD,
  output logic            PCSrcE,
  output logic            PCSrcM,
  output logic            PCSrcW,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic            MemWriteM,
  output logic            MemtoRegE,
  output logic            MemtoRegW,
  output logic            BranchTakenE,
  output logic            PCWrPendingF,
  output logic [RA_W-1:0] WA3M,
  output logic [RA_W-1:0] WA3W,
  output logic            Match_1E_M,
  output logic            Match_1E_W,
  output logic            Match_2E_M,
  output logic            Match_2E_W,
  output logic            Match_12D_E
);

  import hazard_source_pipe_pkg::*;

  localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);

  // ---------------- Decode ----------------
  logic valid_q, valid_d;

  // FlushD beats StallD; otherwise a stall holds and a free slot fills.
  always_comb begin
    valid_d = 1'b1;
    if (FlushD)      valid_d = 1'b0;
    else if (StallD) valid_d = valid_q;
  end

  // D-stage valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  ctrl_t ctrl_dg;
  logic  use1_dg, use2_dg;

  // Raw decode outputs qualified by the D-stage valid bit.
  always_comb begin
    ctrl_dg.RegWrite = RegWriteD  & valid_q;
    ctrl_dg.MemtoReg = MemtoRegD  & valid_q;
    ctrl_dg.MemWrite = MemWriteD  & valid_q;
    ctrl_dg.PCSrc    = PCSrcD_raw & valid_q;
    ctrl_dg.Branch   = BranchD    & valid_q;
    use1_dg          = UseRA1D    & valid_q;
    use2_dg          = UseRA2D    & valid_q;
  end

  // ---------------- D -> E ----------------
  ctrl_t           ctrl_e;
  logic [RA_W-1:0] wa3_e;

  ctrl_stage_reg #(.AW(RA_W)) u_reg_de (
    .clk     (clk),
    .rst     (reset),
    .en_i    (1'b1),
    .flush_i (FlushE),
    .ctrl_i  (ctrl_dg),
    .wa3_i   (WA3D),
    .ctrl_o  (ctrl_e),
    .wa3_o   (wa3_e)
  );

  logic [RA_W-1:0] ra1_e_q, ra2_e_q;
  logic            use1_e_q, use2_e_q;

  // Source addresses and use bits ride alongside the D->E control register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1_e_q  <= '0;
      ra2_e_q  <= '0;
      use1_e_q <= 1'b0;
      use2_e_q <= 1'b0;
    end else begin
      ra1_e_q  <= RA1D;
      ra2_e_q  <= RA2D;
      use1_e_q <= use1_dg & ~FlushE;
      use2_e_q <= use2_dg & ~FlushE;
    end
  end

  // ---------------- Execute ----------------
  ctrl_t ctrl_eg;

  // Condition check: writes and PC updates only survive a passing condition;
  // MemtoReg stays raw so the load-use check sees every load.
  always_comb begin
    ctrl_eg          = ctrl_e;
    ctrl_eg.RegWrite = ctrl_e.RegWrite & CondExE;
    ctrl_eg.MemWrite = ctrl_e.MemWrite & CondExE;
    ctrl_eg.PCSrc    = ctrl_e.PCSrc    & CondExE;
    ctrl_eg.Branch   = ctrl_e.Branch   & CondExE;
  end

  // ---------------- E -> M, M -> W ----------------
  ctrl_t ctrl_m, ctrl_w;

  ctrl_stage_reg #(.AW(RA_W)) u_reg_em (
    .clk     (clk),
    .rst     (reset),
    .en_i    (1'b1),
    .flush_i (1'b0),
    .ctrl_i  (ctrl_eg),
    .wa3_i   (wa3_e),
    .ctrl_o  (ctrl_m),
    .wa3_o   (WA3M)
  );

  ctrl_stage_reg #(.AW(RA_W)) u_reg_mw (
    .clk     (clk),
    .rst     (reset),
    .en_i    (1'b1),
    .flush_i (1'b0),
    .ctrl_i  (ctrl_m),
    .wa3_i   (WA3M),
    .ctrl_o  (ctrl_w),
    .wa3_o   (WA3W)
  );

  // Fields carried to W for uniformity but not consumed there.
  logic unused_w;
  assign unused_w = ^{ctrl_w.MemWrite, ctrl_w.Branch, ctrl_m.Branch};

  // ---------------- Outputs ----------------
  assign PCSrcD       = ctrl_dg.PCSrc;
  assign PCSrcE       = ctrl_eg.PCSrc;
  assign PCSrcM       = ctrl_m.PCSrc;
  assign PCSrcW       = ctrl_w.PCSrc;
  assign RegWriteM    = ctrl_m.RegWrite;
  assign RegWriteW    = ctrl_w.RegWrite;
  assign MemWriteM    = ctrl_m.MemWrite;
  assign MemtoRegE    = ctrl_e.MemtoReg;
  assign MemtoRegW    = ctrl_w.MemtoReg;
  assign BranchTakenE = ctrl_eg.Branch;
  assign PCWrPendingF = ctrl_dg.PCSrc | ctrl_eg.PCSrc | ctrl_m.PCSrc;

  // The PC is never forwarded or interlocked, so it never matches.
  assign Match_1E_M  = use1_e_q & (ra1_e_q == WA3M) & (ra1_e_q != PC_ADDR);
  assign Match_1E_W  = use1_e_q & (ra1_e_q == WA3W) & (ra1_e_q != PC_ADDR);
  assign Match_2E_M  = use2_e_q & (ra2_e_q == WA3M) & (ra2_e_q != PC_ADDR);
  assign Match_2E_W  = use2_e_q & (ra2_e_q == WA3W) & (ra2_e_q != PC_ADDR);
  assign Match_12D_E = (use1_dg & (RA1D == wa3_e) & (RA1D != PC_ADDR))
                     | (use2_dg & (RA2D == wa3_e) & (RA2D != PC_ADDR));

endmodule

// File: tb/tb_hazard_source_pipe.sv
// Directed bench for hazard_source_pipe with hand-computed expectations.
module tb_hazard_source_pipe;

  logic       clk;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       UseRA1D, UseRA2D, RegWriteD, MemtoRegD, MemWriteD;
  logic       PCSrcD_raw, BranchD, CondExE, StallD, FlushD, FlushE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic       RegWriteM, RegWriteW, MemWriteM, MemtoRegE, MemtoRegW;
  logic       BranchTakenE, PCWrPendingF;
  logic [3:0] WA3M, WA3W;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;

  int errors = 0;
  int checks = 0;

  hazard_source_pipe #(.RA_W(4), .PC_REG(15)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .UseRA1D(UseRA1D), .UseRA2D(UseRA2D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .PCSrcD_raw(PCSrcD_raw), .BranchD(BranchD), .CondExE(CondExE),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemWriteM(MemWriteM), .MemtoRegE(MemtoRegE), .MemtoRegW(MemtoRegW),
    .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF),
    .WA3M(WA3M), .WA3W(WA3W),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic nop();
    RA1D = '0; RA2D = '0; WA3D = '0;
    UseRA1D = 1'b0; UseRA2D = 1'b0;
    RegWriteD = 1'b0; MemtoRegD = 1'b0; MemWriteD = 1'b0;
    PCSrcD_raw = 1'b0; BranchD = 1'b0;
  endtask

  initial begin
    nop();
    CondExE = 1'b1; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    // Reset with a live-looking instruction on the D inputs
    reset = 1'b1; RegWriteD = 1'b1; WA3D = 4'd3; UseRA1D = 1'b1; RA1D = 4'd0;
    repeat (3) tick();
    chk("rst_RegWriteM", RegWriteM, 0);
    chk("rst_RegWriteW", RegWriteW, 0);
    chk("rst_WA3M", WA3M, 0);
    chk("rst_WA3W", WA3W, 0);
    chk("rst_PCWrPendingF", PCWrPendingF, 0);
    chk("rst_PCSrcD", PCSrcD, 0);
    chk("rst_Match_12D_E", Match_12D_E, 0);
    chk("rst_MemtoRegE", MemtoRegE, 0);
    chk("rst_BranchTakenE", BranchTakenE, 0);

    // Release: validD rises at edge1, instruction in D until edge2
    UseRA1D = 1'b0; reset = 1'b0;
    tick();
    chk("rel_e1_RegWriteM", RegWriteM, 0);
    tick();
    nop();
    chk("rel_e2_RegWriteM", RegWriteM, 0);
    tick();
    chk("rel_e3_RegWriteM", RegWriteM, 1);
    chk("rel_e3_WA3M", WA3M, 3);
    tick();
    chk("rel_e4_RegWriteW", RegWriteW, 1);
    chk("rel_e4_WA3W", WA3W, 3);
    chk("rel_e4_RegWriteM", RegWriteM, 0);
    repeat (3) tick();

    // Forwarding from M via Rm: ADD R2 then SUB reading R2 as Rm
    RegWriteD = 1'b1; WA3D = 4'd2;
    tick();
    RegWriteD = 1'b1; WA3D = 4'd5; RA1D = 4'd2; UseRA1D = 1'b0; RA2D = 4'd2; UseRA2D = 1'b1;
    settle();
    chk("fwd_Match_12D_E", Match_12D_E, 1);
    tick();
    nop();
    chk("fwd_Match_2E_M", Match_2E_M, 1);
    chk("fwd_Match_1E_M_nouse", Match_1E_M, 0);
    chk("fwd_Match_2E_W", Match_2E_W, 0);
    repeat (3) tick();

    // Forwarding from W via Rn: ADD R2, NOP, SUB reading R2
    RegWriteD = 1'b1; WA3D = 4'd2;
    tick();
    nop();
    tick();
    RegWriteD = 1'b1; WA3D = 4'd5; RA1D = 4'd2; UseRA1D = 1'b1;
    settle();
    chk("fwdw_Match_12D_E", Match_12D_E, 0);
    tick();
    nop();
    chk("fwdw_Match_1E_W", Match_1E_W, 1);
    chk("fwdw_Match_1E_M", Match_1E_M, 0);
    repeat (3) tick();

    // Load-use: LDR R4 in E, dependent reads R4 as Rm
    RegWriteD = 1'b1; MemtoRegD = 1'b1; WA3D = 4'd4;
    tick();
    chk("lu_MemtoRegE", MemtoRegE, 1);
    nop();
    RegWriteD = 1'b1; WA3D = 4'd6; RA2D = 4'd4; UseRA2D = 1'b1;
    StallD = 1'b1; FlushE = 1'b1;
    settle();
    chk("lu_Match_12D_E", Match_12D_E, 1);
    tick();
    chk("lu_bubble_MemtoRegE", MemtoRegE, 0);
    chk("lu_ldr_RegWriteM", RegWriteM, 1);
    chk("lu_bubble_PCWrPendingF", PCWrPendingF, 0);
    StallD = 1'b0; FlushE = 1'b0;
    tick();
    nop();
    chk("lu_Match_2E_W", Match_2E_W, 1);
    chk("lu_MemtoRegW", MemtoRegW, 1);
    chk("lu_RegWriteW", RegWriteW, 1);
    chk("lu_bubble_RegWriteM", RegWriteM, 0);
    repeat (3) tick();

    // Conditional branch, condition fails
    BranchD = 1'b1;
    tick();
    nop(); CondExE = 1'b0;
    settle();
    chk("br_nottaken", BranchTakenE, 0);
    tick();
    CondExE = 1'b1;
    // Conditional branch, condition passes; flush the younger instructions
    BranchD = 1'b1;
    tick();
    nop(); RegWriteD = 1'b1; WA3D = 4'd8;
    FlushD = 1'b1; FlushE = 1'b1;
    settle();
    chk("br_taken", BranchTakenE, 1);
    tick();
    nop(); PCSrcD_raw = 1'b1; RegWriteD = 1'b1; WA3D = 4'd9;
    FlushD = 1'b0; FlushE = 1'b0;
    settle();
    chk("br_squash_PCSrcD", PCSrcD, 0);
    chk("br_squash_PCWrPendingF", PCWrPendingF, 0);
    tick();
    nop();
    settle();
    chk("br_squash_PCWrPendingF_E", PCWrPendingF, 0);
    tick();
    chk("br_squash_RegWriteM", RegWriteM, 0);
    repeat (3) tick();

    // Store gated by condition in Execute
    MemWriteD = 1'b1;
    tick();
    nop(); CondExE = 1'b0;
    tick();
    chk("st_fail_MemWriteM", MemWriteM, 0);
    CondExE = 1'b1; MemWriteD = 1'b1;
    tick();
    nop();
    tick();
    chk("st_pass_MemWriteM", MemWriteM, 1);
    repeat (3) tick();

    // Write to the PC; a following read of R15 must not match
    PCSrcD_raw = 1'b1; RegWriteD = 1'b1; WA3D = 4'd15;
    settle();
    chk("pc_pend_D", PCWrPendingF, 1);
    tick();
    nop(); RA1D = 4'd15; RA2D = 4'd15; UseRA1D = 1'b1; UseRA2D = 1'b1;
    settle();
    chk("pc_pend_E", PCWrPendingF, 1);
    chk("pc_Match_12D_E", Match_12D_E, 0);
    tick();
    nop();
    settle();
    chk("pc_pend_M", PCWrPendingF, 1);
    chk("pc_Match_1E_M", Match_1E_M, 0);
    chk("pc_Match_2E_M", Match_2E_M, 0);
    chk("pc_PCSrcW_early", PCSrcW, 0);
    tick();
    chk("pc_pend_W", PCWrPendingF, 0);
    chk("pc_PCSrcW", PCSrcW, 1);
    chk("pc_Match_1E_W", Match_1E_W, 0);
    repeat (3) tick();

    // StallD and FlushD together: flush wins; then stall alone holds 0
    RegWriteD = 1'b1; WA3D = 4'd1; StallD = 1'b1; FlushD = 1'b1;
    tick();
    nop(); PCSrcD_raw = 1'b1; StallD = 1'b1; FlushD = 1'b0;
    settle();
    chk("sf_flushwins_PCSrcD", PCSrcD, 0);
    tick();
    chk("sf_stallhold_PCSrcD", PCSrcD, 0);
    StallD = 1'b0;
    tick();
    chk("sf_refill_PCSrcD", PCSrcD, 1);
    nop();
    repeat (4) tick();

    // Asynchronous reset mid-operation clears stages without a clock edge
    RegWriteD = 1'b1; WA3D = 4'd7;
    tick();
    nop();
    tick();
    chk("ar_pre_RegWriteM", RegWriteM, 1);
    chk("ar_pre_WA3M", WA3M, 7);
    #2 reset = 1'b1;
    #1;
    chk("ar_RegWriteM", RegWriteM, 0);
    chk("ar_WA3M", WA3M, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_source_pipe.md
Name: hazard_source_pipe

Overview:
Control-side pipeline that feeds the hazard unit and obeys its stall and flush outputs. It carries the decoded control bits and register addresses from Decode through Execute, Memory and Writeback, and applies the condition check in Execute. It produces the register-match, RegWrite, MemtoReg, PCSrc, PCWrPendingF and BranchTakenE signals that the hazard unit consumes. StallD and FlushD act on a D-stage valid bit; FlushE acts on the D→E register.

Parameters:
RA_W, 4, register address width
PC_REG, 15, register index (the PC) excluded from all match outputs

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
RA1D  in  RA_W  Rn address in Decode
RA2D  in  RA_W  Rm address in Decode
WA3D  in  RA_W  destination address in Decode
UseRA1D  in  1  instruction reads RA1D
UseRA2D  in  1  instruction reads RA2D
RegWriteD  in  1  decoded register write
MemtoRegD  in  1  decoded load
MemWriteD  in  1  decoded store
PCSrcD_raw  in  1  decoded write to PC (undeclared branch)
BranchD  in  1  decoded B instruction
CondExE  in  1  condition passed in Execute (from flags logic)
StallD  in  1  from hazard unit
FlushD  in  1  from hazard unit
FlushE  in  1  from hazard unit
PCSrcD, PCSrcE, PCSrcM, PCSrcW  out  1 each  gated PC-write per stage
RegWriteM, RegWriteW  out  1 each
MemWriteM, MemtoRegE, MemtoRegW  out  1 each
BranchTakenE  out  1  BranchE & CondExE
PCWrPendingF  out  1  PCSrcD | PCSrcE | PCSrcM
WA3M, WA3W  out  RA_W each  destination addresses
Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E  out  1 each

Behaviour:
- validD register. On reset it is 0. If FlushD, next value 0. Else if StallD, hold. Else 1. FlushD takes precedence over StallD.
- Decode-stage gated controls equal the raw input AND validD: PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, UseRA1D, UseRA2D.
- D→E register captures the gated controls, addresses and use bits. If FlushE, all control and use bits become 0 and addresses are don't-care. FlushE overrides everything. The D→E register does not stall (an LDR stall always pairs with FlushE).
- In Execute, RegWriteE, MemWriteE and PCSrcE are gated by CondExE. MemtoRegE is the raw value (feeds the load-use check). BranchTakenE = BranchE & CondExE.
- E→M and M→W registers capture every cycle, never stall, and carry the gated values.
- Matches are combinational over registered state. A match requires the address compare, the use bit, and the address not equal to PC_REG:
  - Match_1E_M = UseRA1E & (RA1E==WA3M)
  - Match_1E_W, Match_2E_M, Match_2E_W follow the same form.
  - Match_12D_E = (UseRA1D & RA1D==WA3E) | (UseRA2D & RA2D==WA3E), using D-stage gated use bits.
- Reset: every register and every output is 0, including WA3M/WA3W, so all matches are 0. Reset asserted mid-operation clears all stages immediately; the first instruction after reset release reaches W four cycles later.
- Latency: gated controls go from D to E in 1 cycle, to M in 2, to W in 3.

Decomposition:
- Shared package: RA_W and PC_REG constants, plus a packed ctrl_t struct {RegWrite, MemtoReg, MemWrite, PCSrc, Branch}. The struct is reused by datapath stage registers.
- One sub-module, ctrl_stage_reg: a ctrl_t plus address register with flush and enable inputs. It is instantiated for D→E (enable = 1), E→M and M→W.

Test Plan:
- Reset: hold reset with RegWriteD=1 and WA3D=3 for 3 cycles → all outputs 0; after release, RegWriteM=1 and WA3M=3 appear two cycles after a D-stage instruction is issued.
- Forwarding: ADD writing R2, followed by SUB reading R2 as Rn → Match_1E_M=1 on the cycle SUB is in E; one cycle later with a NOP inserted, Match_1E_W=1.
- Load-use: LDR writing R4 in E with UseRA2D=1 and RA2D=4 → Match_12D_E=1 and MemtoRegE=1. With the hazard unit's StallD/FlushE applied, E shows a bubble (all controls 0) and the dependent instruction issues one cycle later.
- Conditional branch: BranchD=1, then CondExE=0 in E → BranchTakenE=0. Repeat with CondExE=1 → BranchTakenE=1; FlushD=1 next cycle clears validD, so PCSrcD=0 and RegWriteE=0 for the squashed instruction.
- PC write: PCSrcD_raw=1 and RegWriteD=1 with WA3D=15 → PCWrPendingF=1 for 3 consecutive cycles (D, E, M), PCSrcW=1 on the 4th. No Match output asserts for a following read of R15.
- Stall and flush together: StallD=1 and FlushD=1 in the same cycle → validD=0 next cycle (flush wins).
